// File: rtl/line_match_pkg.sv
// Shared constants and state encoding for the receive-side line matcher.
package line_match_pkg;

    localparam int MAX_LEN = 16;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_BS = 8'h08;

    localparam logic KW_HELLO = 1'b0;
    localparam logic KW_BYE   = 1'b1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        COMPARE = 2'd2,
        REPORT  = 2'd3
    } state_t;

    function automatic logic is_print(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/keyword_rom.sv
// Two 16-byte keyword slots, zero padded; one-cycle registered read.
module keyword_rom (
    input  logic       clk,
    input  logic [4:0] addr,
    output logic [7:0] data
);

    logic [7:0] word;

    always_comb begin
        word = 8'h00;
        case (addr)
            5'd0:  word = "h";
            5'd1:  word = "e";
            5'd2:  word = "l";
            5'd3:  word = "l";
            5'd4:  word = "o";
            5'd16: word = "b";
            5'd17: word = "y";
            5'd18: word = "e";
            default: word = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= word;
    end

endmodule

// File: rtl/line_matcher.sv
// Collects an RX line into a 16-byte buffer and, on CR, compares it
// against the keyword ROM, reporting a one-cycle result pulse.
module line_matcher
    import line_match_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       busy,
    output logic       rx_drop,
    output logic       match_valid,
    output logic       match_hit,
    output logic       match_id,
    output logic [4:0] line_len,
    output logic       overflow
);

    localparam logic [4:0] LEN_FULL = 5'(MAX_LEN);
    localparam logic [4:0] ADDR_LAST = 5'd31;

    state_t     state_q, state_d;
    logic [4:0] len_q;
    logic       ovf_q;
    logic [7:0] line_buf [MAX_LEN];

    logic [4:0] addr_q, addr_d_q;
    logic       addr_act_q, cmp_act_q;
    logic       mis0_q, mis1_q;
    logic       mis0_n, mis1_n;
    logic [7:0] rom_data;

    logic       is_cr, is_bs, is_pr;
    logic       cmp_done, cmp_enter;
    logic [3:0] idx;
    logic [7:0] exp_byte;
    logic       byte_miss;

    keyword_rom u_rom (
        .clk  (clk),
        .addr (addr_q),
        .data (rom_data)
    );

    assign is_cr = (rx_data == CHAR_CR);
    assign is_bs = (rx_data == CHAR_BS);
    assign is_pr = is_print(rx_data);

    assign busy        = (state_q == COMPARE) || (state_q == REPORT);
    assign match_valid = (state_q == REPORT);

    assign cmp_done  = cmp_act_q && (addr_d_q == ADDR_LAST);
    assign cmp_enter = (state_q != COMPARE) && (state_d == COMPARE);

    // Bytes past the line end compare against the ROM's zero padding.
    assign idx       = addr_d_q[3:0];
    assign exp_byte  = ({1'b0, idx} < len_q) ? line_buf[idx] : 8'h00;
    assign byte_miss = (rom_data != exp_byte);

    assign mis0_n = mis0_q | (cmp_act_q & ~addr_d_q[4] & byte_miss);
    assign mis1_n = mis1_q | (cmp_act_q &  addr_d_q[4] & byte_miss);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLLECT: begin
                if (rx_valid && is_cr)
                    state_d = COMPARE;
                else if (rx_valid && is_pr && len_q == LEN_FULL)
                    state_d = DISCARD;
            end
            DISCARD: begin
                if (rx_valid && is_cr)
                    state_d = COMPARE;
            end
            COMPARE: begin
                if (cmp_done)
                    state_d = REPORT;
            end
            REPORT: state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == REPORT) begin
            len_q <= '0;
            ovf_q <= 1'b0;
        end else if (state_q == COLLECT && rx_valid) begin
            unique case (1'b1)
                is_pr: begin
                    if (len_q == LEN_FULL)
                        ovf_q <= 1'b1;
                    else
                        len_q <= len_q + 5'd1;
                end
                is_bs: begin
                    if (len_q != 5'd0)
                        len_q <= len_q - 5'd1;
                end
                (rx_data == CHAR_LF): ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == COLLECT && rx_valid && is_pr && len_q != LEN_FULL)
            line_buf[len_q[3:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            addr_d_q   <= '0;
            addr_act_q <= 1'b0;
            cmp_act_q  <= 1'b0;
            mis0_q     <= 1'b0;
            mis1_q     <= 1'b0;
        end else begin
            addr_d_q  <= addr_q;
            cmp_act_q <= addr_act_q;
            if (cmp_enter) begin
                addr_q     <= '0;
                addr_act_q <= 1'b1;
                mis0_q     <= 1'b0;
                mis1_q     <= 1'b0;
            end else begin
                if (addr_act_q) begin
                    addr_q <= addr_q + 5'd1;
                    if (addr_q == ADDR_LAST)
                        addr_act_q <= 1'b0;
                end
                mis0_q <= mis0_n;
                mis1_q <= mis1_n;
            end
        end
    end

    // Results are latched from the final flag values so they are
    // already stable in the REPORT cycle and hold afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_drop   <= 1'b0;
            match_hit <= 1'b0;
            match_id  <= KW_HELLO;
            line_len  <= '0;
            overflow  <= 1'b0;
        end else begin
            rx_drop <= rx_valid & busy;
            if (cmp_done) begin
                match_hit <= ~ovf_q & (~mis0_n | ~mis1_n);
                match_id  <= (mis0_n & ~mis1_n) ? KW_BYE : KW_HELLO;
                line_len  <= len_q;
                overflow  <= ovf_q;
            end
        end
    end

endmodule

// File: tb/tb_line_matcher.sv
// Table-driven scoreboard bench for line_matcher.
module tb_line_matcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy, rx_drop, match_valid, match_hit, match_id;
    logic [4:0] line_len;
    logic       overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [191:0] txt;
        int           n;
        bit           hit;
        bit           id;
        int           len;
        bit           ovf;
    } vec_t;

    typedef struct {
        int cyc;
        bit hit;
        bit id;
        int len;
        bit ovf;
    } exp_t;

    exp_t sb [$];
    vec_t tbl [13];

    line_matcher dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .rx_drop     (rx_drop),
        .match_valid (match_valid),
        .match_hit   (match_hit),
        .match_id    (match_id),
        .line_len    (line_len),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && match_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", int'(match_valid), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("hit", int'(match_hit), int'(e.hit));
                if (e.hit) chk("id", int'(match_id), int'(e.id));
                chk("len", int'(line_len), e.len);
                chk("ovf", int'(overflow), int'(e.ovf));
            end
        end
    end

    function automatic vec_t mk(input logic [191:0] t, input int n,
                                input bit h, input bit id,
                                input int len, input bit ovf);
        vec_t v;
        v.txt = t; v.n = n; v.hit = h; v.id = id;
        v.len = len; v.ovf = ovf;
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic send_line(input vec_t v, input bit push);
        logic [191:0] t;
        exp_t e;
        t = v.txt;
        for (int j = 0; j < v.n; j++)
            send_byte(t[8*(v.n-1-j) +: 8]);
        send_byte(8'h0D);
        e.cyc = cyc + 34;
        e.hit = v.hit; e.id = v.id; e.len = v.len; e.ovf = v.ovf;
        if (push) sb.push_back(e);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sb.size() != 0; i++)
            @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        tbl[0]  = mk("hello", 5, 1, 0, 5, 0);
        tbl[1]  = mk({"bye", 8'h0A}, 4, 1, 1, 3, 0);
        tbl[2]  = mk({"helloo", 8'h08}, 7, 1, 0, 5, 0);
        tbl[3]  = mk("Hello", 5, 0, 0, 5, 0);
        tbl[4]  = mk("hell", 4, 0, 0, 4, 0);
        tbl[5]  = mk("aaaaaaaaaaaaaaaaaaaa", 20, 0, 0, 16, 1);
        tbl[6]  = mk("bye", 3, 1, 1, 3, 0);
        tbl[7]  = mk(192'h0, 0, 0, 0, 0, 0);
        tbl[8]  = mk({"hello", {6{8'h08}}, "bye"}, 14, 1, 1, 3, 0);
        tbl[9]  = mk("hellox", 6, 0, 0, 6, 0);
        tbl[10] = mk({"he", 8'h01, "llo"}, 6, 1, 0, 5, 0);
        tbl[11] = mk("hellohellohelloh", 16, 0, 0, 16, 0);
        tbl[12] = mk("hellohellohellohe", 17, 0, 0, 16, 1);

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_drop", int'(rx_drop), 0);
        chk("rst_valid", int'(match_valid), 0);
        chk("rst_hit", int'(match_hit), 0);
        chk("rst_id", int'(match_id), 0);
        chk("rst_len", int'(line_len), 0);
        chk("rst_ovf", int'(overflow), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            send_line(tbl[i], 1'b1);
            wait_idle();
            @(negedge clk);
            chk("valid_pulse", int'(match_valid), 0);
            chk("busy_low", int'(busy), 0);
            chk("hold_len", int'(line_len), tbl[i].len);
            chk("hold_hit", int'(match_hit), int'(tbl[i].hit));
        end

        // byte strobed mid-compare is dropped
        send_line(mk("hello", 5, 1, 0, 5, 0), 1'b1);
        repeat (9) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = "x";
        @(negedge clk);
        rx_valid = 1'b0;
        chk("drop_pulse", int'(rx_drop), 1);
        chk("drop_busy", int'(busy), 1);
        @(negedge clk);
        chk("drop_clear", int'(rx_drop), 0);
        wait_idle();
        send_line(mk("bye", 3, 1, 1, 3, 0), 1'b1);
        wait_idle();

        // reset in the middle of a comparison
        send_line(mk("hello", 5, 1, 0, 5, 0), 1'b0);
        repeat (19) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(match_valid), 0);
        chk("mid_rst_hit", int'(match_hit), 0);
        chk("mid_rst_id", int'(match_id), 0);
        chk("mid_rst_len", int'(line_len), 0);
        chk("mid_rst_ovf", int'(overflow), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        send_line(mk("hello", 5, 1, 0, 5, 0), 1'b1);
        wait_idle();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_matcher.md
# line_matcher

Receive-side counterpart to the message-ROM transmit path. Collects bytes from the UART receiver into a 16-byte line buffer and, on carriage return, compares the line against two fixed keywords. Reports a one-cycle result pulse with keyword id, hit flag and line length. Sits between the UART RX byte strobe and the control logic that selects which message the transmitter sends.

## Interface
- MAX_LEN, 16: line buffer depth in bytes; also the keyword slot size. Fixed at 16 in this revision.
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- busy  out  1  high while comparing; bytes strobed while high are dropped
- rx_drop  out  1  one-cycle pulse when a byte is dropped because busy=1
- match_valid  out  1  one-cycle result pulse
- match_hit  out  1  line equals a keyword; qualified by match_valid
- match_id  out  1  0 = "hello", 1 = "bye"; qualified by match_hit
- line_len  out  5  accepted bytes in the line (0..16); qualified by match_valid
- overflow  out  1  line exceeded MAX_LEN; qualified by match_valid

## Operation
- States:
  - COLLECT: reset state.
  - DISCARD
  - COMPARE
  - REPORT
- COLLECT:
  - Byte 0x20..0x7E: stored at buf[len], len+1.
  - If len is already 16, go to DISCARD with overflow set.
  - 0x08 (backspace): len-1, saturating at 0.
  - 0x0D (CR): go to COMPARE.
  - 0x0A and all other bytes: ignored.
- DISCARD:
  - All bytes ignored except 0x0D, which goes to COMPARE.
  - len stays 16.
- COMPARE:
  - Issues keyword_rom addresses 0..31 on consecutive cycles.
  - Keyword k matches iff for every i in 0..15: rom[16k+i] == (i < len ? buf[i] : 0x00).
  - One mismatch flag per keyword, cleared on entry.
  - Overflow forces match_hit=0.
- REPORT: one cycle.
  - match_valid=1; match_hit, match_id, line_len, overflow driven.
  - Buffer length and overflow cleared; return to COLLECT.
- Keyword ROM contents:
  - Addresses 0..4 = "hello", 5..15 = 0x00.
  - Addresses 16..18 = "bye", 19..31 = 0x00.
  - Case-sensitive. Keywords contain no 0x00.
- Empty line (CR with len=0): match_hit=0, line_len=0.
- Both mismatch flags clear is impossible. If it occurs, id 0 wins.
- Result outputs hold their values until the next match_valid. match_valid itself is a pulse.

## Timing
- Reset values: busy=0, rx_drop=0, match_valid=0, match_hit=0, match_id=0, line_len=0, overflow=0. State COLLECT, len=0.
- CR sampled at edge T:
  - ROM addresses 0..31 presented in cycles T+1..T+32.
  - Registered ROM data valid T+2..T+33.
  - Mismatch flags final after edge T+33.
  - match_valid high in cycle T+34 (REPORT).
  - Fixed latency: 34 cycles from the CR edge to the result pulse.
- busy is high in cycles T+1..T+34 inclusive.
- rx_valid during busy: byte dropped, rx_drop high the following cycle.
- A byte strobed in cycle T+35 or later is accepted normally.
- Back-to-back rx_valid on consecutive cycles is supported in COLLECT and DISCARD.
- rst_n low at any point:
  - All state and outputs return to reset values immediately.
  - An in-flight comparison is abandoned with no match_valid.
  - Buffer contents are don't-care.

## Structure
- Shared package line_match_pkg holds:
  - constants CHAR_CR=8'h0D, CHAR_LF=8'h0A, CHAR_BS=8'h08, MAX_LEN=16
  - the 2-bit state encoding (COLLECT, DISCARD, COMPARE, REPORT)
  - KW_HELLO=1'b0, KW_BYE=1'b1
- Sub-module keyword_rom:
  - ports: clk, addr[4:0], data[7:0]
  - contents as above, one-cycle registered read
  - same read timing as the transmit message ROM
- Top level holds:
  - FSM and 16x8 buffer
  - 5-bit length counter and 5-bit compare address counter
  - a one-cycle delayed address copy for indexing buf against returning ROM data
  - two mismatch flags

## Test plan
- Send "hello",0x0D → 34 cycles after the CR edge: match_valid=1, match_hit=1, match_id=0, line_len=5, overflow=0.
- Send "bye",0x0A,0x0D → match_hit=1, match_id=1, line_len=3. The LF is ignored.
- Send "helloo",0x08,0x0D → match_hit=1, match_id=0, line_len=5. Send "Hello",0x0D → match_hit=0. Send "hell",0x0D → match_hit=0.
- Send 20 × 'a', then 0x0D → match_valid=1, match_hit=0, overflow=1, line_len=16. Next "bye",0x0D → match_hit=1, overflow=0.
- Send 'x' at T+10 after a CR → rx_drop pulses, busy=1, byte not stored. The following "bye",0x0D still matches with line_len=3.
- Assert rst_n=0 at T+20 of a comparison → outputs at reset values immediately, no match_valid. After release, "hello",0x0D → normal match.
